// File: rtl/f2_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : f2_fetch_queue_if
// Description : Fetch-to-decode bundle for f2_fetch_queue. It carries the
//               cache line hits, the resteer sources and the decode-side
//               offer/accept handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface f2_fetch_queue_if #(
    parameter int XLEN      = 32,
    parameter int CL_SIZE   = 128,
    parameter int DEPTH     = 4,
    parameter int DEC_WIDTH = 2
);
    localparam int c_CBITS = $clog2(DEPTH + 1);

    // Cache side
    logic                   even_valid;
    logic [CL_SIZE-1:0]     even_line;
    logic                   even_exc;
    logic                   odd_valid;
    logic [CL_SIZE-1:0]     odd_line;
    logic                   odd_exc;

    // Resteer sources
    logic                   resteer;
    logic                   rs_taken_rob;
    logic                   rs_taken_d1;
    logic                   rs_taken_br;
    logic                   rs_taken_ras;
    logic [XLEN-1:0]        rs_target_rob;
    logic [XLEN-1:0]        rs_target_d1;
    logic [XLEN-1:0]        rs_target_br;
    logic [XLEN-1:0]        rs_target_ras;

    // Decode side
    logic                   dec_ready;
    logic [DEC_WIDTH-1:0]   dec_valid;
    logic [DEC_WIDTH*32-1:0] dec_instr;
    logic [XLEN-1:0]        dec_pc;
    logic                   dec_exc;
    logic                   stall;
    logic [c_CBITS-1:0]     count;

    // Driver of the cache/resteer/decode-ready signals
    modport master (
        output even_valid, even_line, even_exc,
        output odd_valid, odd_line, odd_exc,
        output resteer, rs_taken_rob, rs_taken_d1, rs_taken_br, rs_taken_ras,
        output rs_target_rob, rs_target_d1, rs_target_br, rs_target_ras,
        output dec_ready,
        input  dec_valid, dec_instr, dec_pc, dec_exc, stall, count
    );

    // The fetch queue itself
    modport slave (
        input  even_valid, even_line, even_exc,
        input  odd_valid, odd_line, odd_exc,
        input  resteer, rs_taken_rob, rs_taken_d1, rs_taken_br, rs_taken_ras,
        input  rs_target_rob, rs_target_d1, rs_target_br, rs_target_ras,
        input  dec_ready,
        output dec_valid, dec_instr, dec_pc, dec_exc, stall, count
    );
endinterface
`default_nettype wire

// File: rtl/f2_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : f2_fetch_queue
// Description : Circular queue of fetched cache lines. It offers up to
//               DEC_WIDTH instructions per cycle from the head line, starting
//               at the word selected by the fetch PC. Groups never cross a
//               line boundary. Resteer flushes the queue and redirects the PC.
//               Optional macro F2Q_BYPASS_EN: when the queue is empty, an
//               incoming line is offered combinationally in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module f2_fetch_queue #(
    parameter int XLEN      = 32,
    parameter int CL_SIZE   = 128,
    parameter int DEPTH     = 4,
    parameter int DEC_WIDTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    f2_fetch_queue_if.slave   bus
);
    localparam int c_WPL   = CL_SIZE / 32;
    localparam int c_WBITS = (c_WPL > 1) ? $clog2(c_WPL) : 1;
    localparam int c_PBITS = $clog2(DEPTH);
    localparam int c_CBITS = $clog2(DEPTH + 1);
    localparam logic [c_WBITS:0]   c_WPL_W   = (c_WBITS + 1)'(c_WPL);
    localparam logic [c_WBITS:0]   c_DW_W    = (c_WBITS + 1)'(DEC_WIDTH);
    localparam logic [c_CBITS-1:0] c_DEPTH_C = c_CBITS'(DEPTH);

    // Queue storage and pointers
    logic [CL_SIZE-1:0]  r_line [DEPTH];
    logic                r_exc  [DEPTH];
    logic [DEPTH-1:0]    r_valid;
    logic [c_PBITS-1:0]  r_head;
    logic [c_PBITS-1:0]  r_tail;
    logic [c_CBITS-1:0]  r_count;
    logic [XLEN-1:0]     r_pc;

    logic                w_have;
    logic [1:0]          w_n;
    logic [c_CBITS-1:0]  w_free;
    logic                w_stall_raw;
    logic                w_byp_active;
    logic [CL_SIZE-1:0]  w_byp_line;
    logic                w_byp_exc;
    logic                w_offer;
    logic [CL_SIZE-1:0]  w_src_line;
    logic                w_src_exc;
    logic [31:0]         w_words [c_WPL];
    logic [c_WBITS-1:0]  w_word;
    logic [c_WBITS:0]    w_rem;
    logic [c_WBITS:0]    w_k;
    logic [DEC_WIDTH-1:0] w_valid;
    logic [DEC_WIDTH*32-1:0] w_instr;
    logic                w_fire;
    logic                w_done;
    logic                w_pop;
    logic                w_byp_skip;
    logic                w_wr_even;
    logic                w_wr_odd;
    logic [c_CBITS-1:0]  w_nwr;
    logic [c_PBITS-1:0]  w_odd_slot;
    logic                w_rs_any;
    logic [XLEN-1:0]     w_rs_target;

    // Occupancy and all-or-nothing admission against start-of-cycle count
    assign w_have      = (r_count != '0) && r_valid[r_head];
    assign w_n         = {1'b0, bus.even_valid} + {1'b0, bus.odd_valid};
    assign w_free      = c_DEPTH_C - r_count;
    assign w_stall_raw = (c_CBITS'(w_n) > w_free);

    // The line that would be bypassed: even takes precedence over odd
    assign w_byp_line = bus.even_valid ? bus.even_line : bus.odd_line;
    assign w_byp_exc  = bus.even_valid ? bus.even_exc  : bus.odd_exc;

`ifdef F2Q_BYPASS_EN
    assign w_byp_active = !rst && !bus.resteer && (r_count == '0) &&
                          (bus.even_valid || bus.odd_valid);
`else
    assign w_byp_active = 1'b0;
`endif

    // Offer source: head entry when present, otherwise the bypass line
    assign w_offer    = !rst && (w_have || w_byp_active);
    assign w_src_line = w_have ? r_line[r_head] : w_byp_line;
    assign w_src_exc  = w_have ? r_exc[r_head]  : w_byp_exc;

    for (genvar gi = 0; gi < c_WPL; gi++) begin : g_words
        assign w_words[gi] = w_src_line[32*gi +: 32];
    end

    // Group size is clipped at the end of the line so groups never straddle lines
    assign w_word = (c_WPL > 1) ? r_pc[c_WBITS+1:2] : '0;
    assign w_rem  = c_WPL_W - {1'b0, w_word};
    assign w_k    = (w_rem < c_DW_W) ? w_rem : c_DW_W;

    // Slot i carries word w+i of the source line while i < k
    always_comb begin
        logic [c_WBITS-1:0] v_idx;
        w_valid = '0;
        w_instr = '0;
        v_idx   = '0;
        for (int i = 0; i < DEC_WIDTH; i++) begin
            v_idx = w_word + c_WBITS'(i);
            if (w_offer && ((c_WBITS + 1)'(i) < w_k)) begin
                w_valid[i]         = 1'b1;
                w_instr[32*i +: 32] = w_words[v_idx];
            end
        end
    end

    // Dequeue bookkeeping: a bypassed line fully consumed is never written
    assign w_fire     = bus.dec_ready && w_valid[0];
    assign w_done     = w_fire && (w_k == w_rem);
    assign w_pop      = w_done && w_have;
    assign w_byp_skip = w_done && !w_have;
    assign w_wr_even  = bus.even_valid && !w_byp_skip;
    assign w_wr_odd   = bus.odd_valid && !(w_byp_skip && !bus.even_valid);
    assign w_nwr      = c_CBITS'(w_wr_even) + c_CBITS'(w_wr_odd);
    assign w_odd_slot = r_tail + c_PBITS'(w_wr_even);

    // Resteer target selection, ROB highest priority down to RAS
    always_comb begin
        w_rs_any    = 1'b1;
        w_rs_target = r_pc;
        if (bus.rs_taken_rob)      w_rs_target = bus.rs_target_rob;
        else if (bus.rs_taken_d1)  w_rs_target = bus.rs_target_d1;
        else if (bus.rs_taken_br)  w_rs_target = bus.rs_target_br;
        else if (bus.rs_taken_ras) w_rs_target = bus.rs_target_ras;
        else                       w_rs_any    = 1'b0;
    end

    // Control state: reset beats resteer, resteer beats enqueue/dequeue
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else if (bus.resteer) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            if (w_rs_any) begin
                r_pc <= w_rs_target;
            end
        end else begin
            if (w_fire) begin
                r_pc <= r_pc + XLEN'({w_k, 2'b00});
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (!w_stall_raw) begin
                if (w_wr_even) r_valid[r_tail]     <= 1'b1;
                if (w_wr_odd)  r_valid[w_odd_slot] <= 1'b1;
                r_tail <= r_tail + c_PBITS'(w_nwr);
            end
            r_count <= r_count + (w_stall_raw ? '0 : w_nwr) - c_CBITS'(w_pop);
        end
    end

    // Line payload writes; data is qualified by r_valid so it needs no reset
    always_ff @(posedge clk) begin
        if (!rst && !bus.resteer && !w_stall_raw) begin
            if (w_wr_even) begin
                r_line[r_tail] <= bus.even_line;
                r_exc[r_tail]  <= bus.even_exc;
            end
            if (w_wr_odd) begin
                r_line[w_odd_slot] <= bus.odd_line;
                r_exc[w_odd_slot]  <= bus.odd_exc;
            end
        end
    end

    assign bus.dec_valid = w_valid;
    assign bus.dec_instr = w_instr;
    assign bus.dec_pc    = r_pc;
    assign bus.dec_exc   = w_offer && w_src_exc;
    assign bus.stall     = !rst && !bus.resteer && w_stall_raw;
    assign bus.count     = r_count;
endmodule
`default_nettype wire

// File: tb/tb_f2_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_f2_fetch_queue
// Description : Self-checking bench for f2_fetch_queue: table vectors,
//               directed corner sequences and a randomized run against a
//               queue-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_f2_fetch_queue;
    localparam int XLEN      = 32;
    localparam int CL_SIZE   = 128;
    localparam int DEPTH     = 4;
    localparam int DEC_WIDTH = 2;
    localparam int WPL       = CL_SIZE / 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    f2_fetch_queue_if #(.XLEN(XLEN), .CL_SIZE(CL_SIZE), .DEPTH(DEPTH), .DEC_WIDTH(DEC_WIDTH)) bus ();

    f2_fetch_queue #(.XLEN(XLEN), .CL_SIZE(CL_SIZE), .DEPTH(DEPTH), .DEC_WIDTH(DEC_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Sampled DUT outputs of the current cycle
    logic [DEC_WIDTH-1:0]    a_valid;
    logic [DEC_WIDTH*32-1:0] a_instr;
    logic [XLEN-1:0]         a_pc;
    logic                    a_exc;
    logic                    a_stall;
    logic [2:0]              a_count;

    // Reference model: a queue of whole lines plus the next-instruction PC
    typedef struct packed {
        logic [CL_SIZE-1:0] line;
        logic               exc;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_known = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [CL_SIZE-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive(input logic r, input logic ev, input logic ov, input logic rdy, input logic rs);
        rst            = r;
        bus.even_valid = ev;
        bus.odd_valid  = ov;
        bus.dec_ready  = rdy;
        bus.resteer    = rs;
    endtask

    task automatic clr_taken();
        bus.rs_taken_rob = 1'b0;
        bus.rs_taken_d1  = 1'b0;
        bus.rs_taken_br  = 1'b0;
        bus.rs_taken_ras = 1'b0;
    endtask

    // One clock: sample mid-cycle, compare against the model, advance the model
    task automatic step();
        int   n, w, k;
        bit   offer, from_byp, fire, done, e_stall;
        ent_t src;
        ent_t pend[$];
        #4;
        a_valid = bus.dec_valid;
        a_instr = bus.dec_instr;
        a_pc    = bus.dec_pc;
        a_exc   = bus.dec_exc;
        a_stall = bus.stall;
        a_count = bus.count;
        n = int'(bus.even_valid) + int'(bus.odd_valid);
        if (rst) begin
            chk("rst_valid", a_valid, 0);
            chk("rst_exc", a_exc, 0);
            chk("rst_stall", a_stall, 0);
            mq.delete();
            m_pc    = 32'h0;
            m_known = 1'b1;
        end else if (m_known) begin
            w = int'(m_pc[31:2]) % WPL;
            k = (WPL - w < DEC_WIDTH) ? WPL - w : DEC_WIDTH;
            offer    = 1'b0;
            from_byp = 1'b0;
            src      = '0;
            if (mq.size() > 0) begin
                offer = 1'b1;
                src   = mq[0];
            end
`ifdef F2Q_BYPASS_EN
            else if (!bus.resteer && (bus.even_valid || bus.odd_valid)) begin
                offer    = 1'b1;
                from_byp = 1'b1;
                src.line = bus.even_valid ? bus.even_line : bus.odd_line;
                src.exc  = bus.even_valid ? bus.even_exc  : bus.odd_exc;
            end
`endif
            e_stall = !bus.resteer && (n > DEPTH - mq.size());
            chk("count", a_count, mq.size());
            chk("stall", a_stall, e_stall);
            chk("exc", a_exc, offer && src.exc);
            for (int i = 0; i < DEC_WIDTH; i++) begin
                chk("slot_valid", a_valid[i], offer && (i < k));
                if (offer && i < k)
                    chk("slot_instr", a_instr[32*i +: 32], src.line[32*(w+i) +: 32]);
            end
            if (offer) chk("dec_pc", a_pc, m_pc);

            if (bus.resteer) begin
                mq.delete();
                if (bus.rs_taken_rob)      m_pc = bus.rs_target_rob;
                else if (bus.rs_taken_d1)  m_pc = bus.rs_target_d1;
                else if (bus.rs_taken_br)  m_pc = bus.rs_target_br;
                else if (bus.rs_taken_ras) m_pc = bus.rs_target_ras;
            end else begin
                fire = offer && bus.dec_ready;
                done = fire && (w + k == WPL);
                if (fire) m_pc = m_pc + 32'(4 * k);
                if (done && !from_byp) void'(mq.pop_front());
                if (!e_stall) begin
                    if (bus.even_valid) pend.push_back('{bus.even_line, bus.even_exc});
                    if (bus.odd_valid)  pend.push_back('{bus.odd_line, bus.odd_exc});
                    if (done && from_byp) void'(pend.pop_front());
                    foreach (pend[j]) mq.push_back(pend[j]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       r, ev, ov, rs;
        logic       exp_stall;
        int         exp_count;
        logic       chk_v;
        logic [1:0] exp_valid;
    } vec_t;

    vec_t tbl[18];
    logic [31:0] grp_pc [4];
    logic [63:0] grp_in [4];
    int          ng;
    logic [CL_SIZE-1:0] l0;

    initial begin
        // Table: fill without decode, overflow, all-or-nothing, reset/resteer override
        tbl[0]  = '{0, 1, 0, 0, 0, 0, 0, 2'b00};
        tbl[1]  = '{0, 1, 0, 0, 0, 1, 1, 2'b11};
        tbl[2]  = '{0, 1, 0, 0, 0, 2, 1, 2'b11};
        tbl[3]  = '{0, 1, 0, 0, 0, 3, 1, 2'b11};
        tbl[4]  = '{0, 1, 0, 0, 1, 4, 1, 2'b11};
        tbl[5]  = '{0, 0, 0, 0, 0, 4, 1, 2'b11};
        tbl[6]  = '{1, 1, 0, 0, 0, 4, 1, 2'b00};
        tbl[7]  = '{0, 1, 0, 0, 0, 0, 0, 2'b00};
        tbl[8]  = '{0, 1, 0, 0, 0, 1, 1, 2'b11};
        tbl[9]  = '{0, 1, 0, 0, 0, 2, 1, 2'b11};
        tbl[10] = '{0, 1, 1, 0, 1, 3, 1, 2'b11};
        tbl[11] = '{0, 0, 0, 0, 0, 3, 1, 2'b11};
        tbl[12] = '{0, 1, 1, 1, 0, 3, 1, 2'b11};
        tbl[13] = '{0, 1, 0, 0, 0, 0, 0, 2'b00};
        tbl[14] = '{0, 1, 0, 0, 0, 1, 1, 2'b11};
        tbl[15] = '{0, 1, 1, 0, 0, 2, 1, 2'b11};
        tbl[16] = '{0, 0, 0, 0, 0, 4, 1, 2'b11};
        tbl[17] = '{1, 0, 0, 0, 0, 4, 1, 2'b00};

        clr_taken();
        bus.rs_target_rob = '0;
        bus.rs_target_d1  = '0;
        bus.rs_target_br  = '0;
        bus.rs_target_ras = '0;
        bus.even_line = '0;
        bus.odd_line  = '0;
        bus.even_exc  = 1'b0;
        bus.odd_exc   = 1'b0;
        drive(1, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        step();
        step();
        chk("reset_count", a_count, 0);

        for (int t = 0; t < 18; t++) begin
            drive(tbl[t].r, tbl[t].ev, tbl[t].ov, 0, tbl[t].rs);
            bus.even_line = rnd_line();
            bus.odd_line  = rnd_line();
            step();
            chk("tbl_stall", a_stall, tbl[t].exp_stall);
            if (!tbl[t].r) chk("tbl_count", a_count, tbl[t].exp_count);
            if (tbl[t].chk_v) chk("tbl_valid", a_valid, tbl[t].exp_valid);
        end
        drive(0, 0, 0, 0, 0);
        step();
        chk("post_rst_count", a_count, 0);

        // Two lines, words 0..7, drained in four groups of two
        for (int i = 0; i < 4; i++) begin
            bus.even_line[32*i +: 32] = 32'hC0DE_0000 + i;
            bus.odd_line[32*i +: 32]  = 32'hC0DE_0004 + i;
        end
        drive(0, 1, 1, 1, 0);
        ng = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (a_valid[0] && ng < 4) begin
                grp_pc[ng] = a_pc;
                grp_in[ng] = a_instr;
                ng++;
            end
            drive(0, 0, 0, 1, 0);
        end
        chk("groups_seen", ng, 4);
        for (int g = 0; g < 4; g++) begin
            chk("group_pc", grp_pc[g], 32'(8 * g));
            chk("group_instr", grp_in[g], {32'hC0DE_0000 + 32'(2*g+1), 32'hC0DE_0000 + 32'(2*g)});
        end
        chk("drained_valid", a_valid, 2'b00);

        // Resteer priority ROB > D1 > BR > RAS; no select holds pc
        drive(0, 1, 0, 0, 0);
        bus.even_line = rnd_line();
        step();
        drive(0, 0, 0, 0, 1);
        bus.rs_taken_rob = 1; bus.rs_target_rob = 32'h100;
        bus.rs_taken_br  = 1; bus.rs_target_br  = 32'h200;
        step();
        clr_taken();
        drive(0, 0, 0, 0, 0);
        step();
        chk("rs_rob_pc", a_pc, 32'h100);
        chk("rs_count", a_count, 0);
        chk("rs_valid", a_valid, 2'b00);
        drive(0, 0, 0, 0, 1);
        bus.rs_taken_d1 = 1; bus.rs_target_d1 = 32'h300;
        bus.rs_taken_br = 1; bus.rs_taken_ras = 1; bus.rs_target_ras = 32'h400;
        step();
        clr_taken();
        drive(0, 0, 0, 0, 0);
        step();
        chk("rs_d1_pc", a_pc, 32'h300);
        drive(0, 0, 0, 0, 1);
        bus.rs_taken_br = 1; bus.rs_taken_ras = 1;
        step();
        clr_taken();
        drive(0, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        chk("rs_hold_pc", a_pc, 32'h200);

        // Mid-line resteer target: first group starts at word 3, then head pops
        drive(0, 0, 0, 0, 1);
        bus.rs_taken_rob = 1; bus.rs_target_rob = 32'h10C;
        step();
        clr_taken();
        l0 = rnd_line();
        bus.even_line = l0;
        drive(0, 1, 0, 0, 0);
        step();
        drive(0, 0, 0, 1, 0);
        step();
        chk("mid_valid", a_valid, 2'b01);
        chk("mid_instr", a_instr[31:0], l0[127:96]);
        chk("mid_pc", a_pc, 32'h10C);
        drive(0, 0, 0, 0, 0);
        step();
        chk("mid_pop_count", a_count, 0);
        chk("mid_next_pc", a_pc, 32'h110);

        // Empty-queue latency with and without the bypass path
        drive(1, 0, 0, 0, 0);
        step();
        drive(0, 1, 0, 1, 0);
        bus.even_line = rnd_line();
        step();
`ifdef F2Q_BYPASS_EN
        chk("lat_first", a_valid, 2'b11);
`else
        chk("lat_first", a_valid, 2'b00);
`endif
        drive(0, 0, 0, 1, 0);
        step();
        chk("lat_second", a_valid, 2'b11);

        // Randomized traffic checked against the model
        for (int c = 0; c < 3000; c++) begin
            clr_taken();
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 19) == 0));
            bus.even_line = rnd_line();
            bus.odd_line  = rnd_line();
            bus.even_exc  = ($urandom_range(0, 9) == 0);
            bus.odd_exc   = ($urandom_range(0, 9) == 0);
            bus.rs_taken_rob  = $urandom_range(0, 3) == 0;
            bus.rs_taken_d1   = $urandom_range(0, 3) == 0;
            bus.rs_taken_br   = $urandom_range(0, 3) == 0;
            bus.rs_taken_ras  = $urandom_range(0, 3) == 0;
            bus.rs_target_rob = {20'h0, 10'($urandom), 2'b00};
            bus.rs_target_d1  = {20'h0, 10'($urandom), 2'b00};
            bus.rs_target_br  = {20'h0, 10'($urandom), 2'b00};
            bus.rs_target_ras = {20'h0, 10'($urandom), 2'b00};
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/f2_fetch_queue.md
F2_FETCH_QUEUE -- requirements
Module: f2_fetch_queue

Interface
REQ-001 Parameters: XLEN=32, instruction/PC width; CL_SIZE=128, cache line bits, multiple of 32; DEPTH=4, line entries, power of two, >=2; DEC_WIDTH=2, instructions offered per cycle, 1..CL_SIZE/32.
REQ-002 Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- even_valid  in  1  even cache line hit this cycle.
- even_line  in  CL_SIZE  even line data.
- even_exc  in  1  fetch exception for even line.
- odd_valid  in  1  odd cache line hit this cycle.
- odd_line  in  CL_SIZE  odd line data.
- odd_exc  in  1  fetch exception for odd line.
- resteer  in  1  flush request.
- rs_taken_rob, rs_taken_d1, rs_taken_br, rs_taken_ras  in  1 each  resteer source selects.
- rs_target_rob, rs_target_d1, rs_target_br, rs_target_ras  in  XLEN each  resteer targets.
- dec_ready  in  1  decode accepts offered group.
- dec_valid  out  DEC_WIDTH  per-slot instruction valid, slot 0 oldest.
- dec_instr  out  DEC_WIDTH*32  instructions, slot i at bits [32i+31:32i].
- dec_pc  out  XLEN  PC of slot 0.
- dec_exc  out  1  head line carries exception.
- stall  out  1  enqueue refused this cycle.
- count  out  clog2(DEPTH+1)  occupied entries.

Function
REQ-003 Circular queue of DEPTH entries {line, exc}; head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
REQ-004 Enqueue request n = even_valid + odd_valid; even written before odd; odd-only writes one entry.
REQ-005 stall = (n > DEPTH - count), using start-of-cycle count; no credit for a same-cycle pop.
REQ-006 Enqueue is all-or-nothing: when stall=1, neither line is written.
REQ-007 pc register holds the address of the next undelivered instruction; word offset w = pc[clog2(CL_SIZE/32)+1:2].
REQ-008 When count>0: k = min(DEC_WIDTH, CL_SIZE/32 - w); dec_valid[i]=1 for i<k; slot i = head word w+i; dec_pc = pc; dec_exc = head exc.
REQ-009 Offered groups never cross a line boundary.
REQ-010 When count=0 (and bypass inactive): dec_valid=0, dec_exc=0.
REQ-011 Dequeue fires when dec_ready && dec_valid[0]: pc += 4*k; head pops when w+k == CL_SIZE/32.
REQ-012 Simultaneous enqueue and pop update count by n_written - pop.
REQ-013 Resteer has priority over enqueue and dequeue: count, head and tail go to 0; that cycle's input lines are dropped; stall=0; dec_valid=0 from the next cycle.
REQ-014 Resteer PC select priority ROB > D1 > BR > RAS; with no select asserted, the queue flushes and pc holds.
REQ-015 A resteer to a mid-line target leaves w nonzero, so the first group starts mid-line.
REQ-016 All outputs except stall and the bypass path derive from registered state; normal enqueue-to-offer latency is 1 cycle.

Reset
REQ-017 On rst: pc=0, head=tail=0, count=0, all entry valids cleared.
REQ-018 Outputs during and after rst: dec_valid=0, dec_exc=0, stall=0.
REQ-019 rst overrides resteer and all inputs in the same cycle.

Configuration
REQ-020 Macro F2Q_BYPASS_EN.
- Defined: when count=0, no resteer and even_valid (else odd_valid), that line is offered combinationally the same cycle per REQ-008.
- Bypass line is accepted by dec_ready: if fully consumed it is not written; otherwise it is enqueued with pc advanced.
- Not defined: no bypass path; latency strictly per REQ-016.

Verification
REQ-021 Scenarios:
- Reset, then even_valid and odd_valid in one cycle with words 0..7, dec_ready=1 -> groups {w0,w1} at pc 0x0, {w2,w3} at 0x8, {w4,w5} at 0x10, {w6,w7} at 0x18, then dec_valid=0.
- Four single-line pushes, dec_ready=0 -> count=4; next push -> stall=1, count stays 4.
- count=3 with both lines valid -> stall=1, nothing written; repeat with count=2 -> count=4.
- rs_taken_rob (target 0x100) and rs_taken_br (target 0x200) with resteer=1 -> pc=0x100, count=0, dec_valid=0 next cycle.
- Resteer to 0x10C, then one line hit -> first group dec_valid=01 with w3 at pc 0x10C, then the head pops.
- With F2Q_BYPASS_EN, empty queue, even_valid and dec_ready=1 -> dec_valid=11 in the same cycle; without it -> dec_valid=11 one cycle later.
